// File: rtl/bf2_stage_pkg.sv
// Shared arithmetic for the radix-2 butterfly stages: one-bit-wider
// add/sub/negate followed by a wrap or clamp back down to the port width.
package bf2_stage_pkg;

  localparam int WIDTH_DEFAULT = 16;

  // Functions work on a fixed container wide enough for any supported WIDTH;
  // callers sign-extend into it and truncate the result back to WIDTH.
  localparam int MAX_WIDTH = 32;

  typedef logic signed [MAX_WIDTH-1:0] word_t;
  typedef logic signed [MAX_WIDTH:0]   wide_t;

  // Bring an exact result back into a w-bit signed range, either by wrapping
  // modulo 2^w or by clamping to the w-bit limits.
  function automatic word_t reduce(input wide_t v, input int w, input bit sat);
    wide_t hi;
    wide_t lo;
    wide_t t;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo = -hi - wide_t'(1);
    if (sat) begin
      if (v > hi)      t = hi;
      else if (v < lo) t = lo;
      else             t = v;
    end else begin
      t = (v <<< (MAX_WIDTH + 1 - w)) >>> (MAX_WIDTH + 1 - w);
    end
    return word_t'(t);
  endfunction

  function automatic word_t add_sat(input word_t a, input word_t b, input int w, input bit sat);
    return reduce(wide_t'(a) + wide_t'(b), w, sat);
  endfunction

  function automatic word_t sub_sat(input word_t a, input word_t b, input int w, input bit sat);
    return reduce(wide_t'(a) - wide_t'(b), w, sat);
  endfunction

  // Negating the most negative value is the one case that leaves the range.
  function automatic word_t neg_sat(input word_t a, input int w, input bit sat);
    return reduce(-wide_t'(a), w, sat);
  endfunction

endpackage

// File: rtl/bf2_stage_if.sv
// Data bundle between stage-1 results (C/D) and the stage-2 bins (A).
interface bf2_stage_if #(
  parameter int WIDTH = 16
);
  logic signed [WIDTH-1:0] C_0_re;
  logic signed [WIDTH-1:0] C_1_re;
  logic signed [WIDTH-1:0] D_0_re;
  logic signed [WIDTH-1:0] D_1_re;
  logic signed [WIDTH-1:0] A_0_re;
  logic signed [WIDTH-1:0] A_1_re;
  logic signed [WIDTH-1:0] A_1_im;
  logic signed [WIDTH-1:0] A_2_re;
  logic signed [WIDTH-1:0] A_3_re;
  logic signed [WIDTH-1:0] A_3_im;

  modport master (
    output C_0_re, C_1_re, D_0_re, D_1_re,
    input  A_0_re, A_1_re, A_1_im, A_2_re, A_3_re, A_3_im
  );

  modport slave (
    input  C_0_re, C_1_re, D_0_re, D_1_re,
    output A_0_re, A_1_re, A_1_im, A_2_re, A_3_re, A_3_im
  );
endinterface

// File: rtl/bf2_stage_bf1.sv
// Registered add/sub pair: g_0 = x_0 + x_1, g_1 = x_0 - x_1, one cycle latency.
// Used both as the stage-1 butterfly and for the real bins of stage 2.
module bf1
  import bf2_stage_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEFAULT,
  parameter int SATURATE = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] x_0,
  input  logic signed [WIDTH-1:0] x_1,
  output logic signed [WIDTH-1:0] g_0,
  output logic signed [WIDTH-1:0] g_1
);

  localparam bit SAT = (SATURATE != 0);

  // Sum and difference registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      g_0 <= '0;
      g_1 <= '0;
    end else begin
      g_0 <= WIDTH'(add_sat(word_t'(x_0), word_t'(x_1), WIDTH, SAT));
      g_1 <= WIDTH'(sub_sat(word_t'(x_0), word_t'(x_1), WIDTH, SAT));
    end
  end

endmodule

// File: rtl/bf2_stage.sv
// Stage-2 radix-2 butterfly with twiddle -j. Bins 0/2 come from a bf1
// add/sub pair; bins 1/3 only need a copy of C_1 and +/- D_1 on the
// imaginary side, so no multiplier is involved.
module bf2_stage
  import bf2_stage_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEFAULT,
  parameter int SATURATE = 0
) (
  input  logic        clk,
  input  logic        reset,
  bf2_stage_if.slave  bus
);

  localparam bit SAT = (SATURATE != 0);

  bf1 #(
    .WIDTH    (WIDTH),
    .SATURATE (SATURATE)
  ) u_bf1 (
    .clk   (clk),
    .reset (reset),
    .x_0   (bus.C_0_re),
    .x_1   (bus.D_0_re),
    .g_0   (bus.A_0_re),
    .g_1   (bus.A_2_re)
  );

  // Bins 1 and 3: real parts are plain copies of C_1, imaginary parts are
  // -D_1 (can overflow at the negative limit) and D_1 (never overflows).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.A_1_re <= '0;
      bus.A_1_im <= '0;
      bus.A_3_re <= '0;
      bus.A_3_im <= '0;
    end else begin
      bus.A_1_re <= bus.C_1_re;
      bus.A_1_im <= WIDTH'(neg_sat(word_t'(bus.D_1_re), WIDTH, SAT));
      bus.A_3_re <= bus.C_1_re;
      bus.A_3_im <= bus.D_1_re;
    end
  end

endmodule

// File: tb/tb_bf2_stage.sv
// Directed bench for bf2_stage: wrap and saturate instances side by side,
// plus a two-bf1 front end chained into a third stage.
module tb_bf2_stage;

  logic clk;
  logic reset;
  int   n_run;
  int   n_fail;

  string nm [6] = '{"A0", "A1re", "A1im", "A2", "A3re", "A3im"};

  bf2_stage_if #(.WIDTH(16)) if0 ();
  bf2_stage_if #(.WIDTH(16)) if1 ();
  bf2_stage_if #(.WIDTH(16)) ifc ();

  logic signed [15:0] x0, x4, x2, x6;

  bf2_stage #(.WIDTH(16), .SATURATE(0)) dut0 (.clk(clk), .reset(reset), .bus(if0));
  bf2_stage #(.WIDTH(16), .SATURATE(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));

  bf1 #(.WIDTH(16), .SATURATE(0)) u_even (
    .clk(clk), .reset(reset), .x_0(x0), .x_1(x4), .g_0(ifc.C_0_re), .g_1(ifc.C_1_re)
  );
  bf1 #(.WIDTH(16), .SATURATE(0)) u_odd (
    .clk(clk), .reset(reset), .x_0(x2), .x_1(x6), .g_0(ifc.D_0_re), .g_1(ifc.D_1_re)
  );
  bf2_stage #(.WIDTH(16), .SATURATE(0)) dutc (.clk(clk), .reset(reset), .bus(ifc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [95:0] pk(int a0, int a1r, int a1i, int a2, int a3r, int a3i);
    return {16'(a0), 16'(a1r), 16'(a1i), 16'(a2), 16'(a3r), 16'(a3i)};
  endfunction

  function automatic logic [95:0] snap0();
    return {if0.A_0_re, if0.A_1_re, if0.A_1_im, if0.A_2_re, if0.A_3_re, if0.A_3_im};
  endfunction

  function automatic logic [95:0] snap1();
    return {if1.A_0_re, if1.A_1_re, if1.A_1_im, if1.A_2_re, if1.A_3_re, if1.A_3_im};
  endfunction

  function automatic logic [95:0] snapc();
    return {ifc.A_0_re, ifc.A_1_re, ifc.A_1_im, ifc.A_2_re, ifc.A_3_re, ifc.A_3_im};
  endfunction

  task automatic drive(input int c0, input int c1, input int d0, input int d1);
    if0.C_0_re = 16'(c0); if0.C_1_re = 16'(c1); if0.D_0_re = 16'(d0); if0.D_1_re = 16'(d1);
    if1.C_0_re = 16'(c0); if1.C_1_re = 16'(c1); if1.D_0_re = 16'(d0); if1.D_1_re = 16'(d1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [95:0] got, exp;
    reset = 1'b1;
    drive(100, 200, 300, 400);
    repeat (3) @(posedge clk);
    #1;
    got = snap0();
    for (int i = 0; i < 6; i++) begin
      n_run++;
      if (got[(5-i)*16 +: 16] !== 16'd0) begin
        n_fail++;
        $display("FAIL reset_hold_w_%s got %0d exp 0", nm[i], $signed(got[(5-i)*16 +: 16]));
      end
    end
    got = snap1();
    n_run++;
    if (got !== 96'd0) begin
      n_fail++;
      $display("FAIL reset_hold_s got %h exp 0", got);
    end
    // first edge after release captures the pending inputs
    reset = 1'b0;
    step();
    got = snap0();
    exp = pk(400, 200, -400, -200, 200, 400);
    for (int i = 0; i < 6; i++) begin
      n_run++;
      if (got[(5-i)*16 +: 16] !== exp[(5-i)*16 +: 16]) begin
        n_fail++;
        $display("FAIL release_%s got %0d exp %0d", nm[i],
                 $signed(got[(5-i)*16 +: 16]), $signed(exp[(5-i)*16 +: 16]));
      end
    end
    // assert between edges: outputs must clear without a clock
    #2;
    reset = 1'b1;
    #1;
    got = snap0();
    n_run++;
    if (got !== 96'd0) begin
      n_fail++;
      $display("FAIL async_clear_w got %h exp 0", got);
    end
    got = snap1();
    n_run++;
    if (got !== 96'd0) begin
      n_fail++;
      $display("FAIL async_clear_s got %h exp 0", got);
    end
    #1;
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [95:0] got, exp;
    drive(2825, -1823, -300, 760);
    step();
    got = snap0();
    exp = pk(2525, -1823, -760, 3125, -1823, 760);
    for (int i = 0; i < 6; i++) begin
      n_run++;
      if (got[(5-i)*16 +: 16] !== exp[(5-i)*16 +: 16]) begin
        n_fail++;
        $display("FAIL cycA_%s got %0d exp %0d", nm[i],
                 $signed(got[(5-i)*16 +: 16]), $signed(exp[(5-i)*16 +: 16]));
      end
    end
    drive(300, 908, 700, -2730);
    #2;
    n_run++;
    if (if0.A_0_re !== 16'sd2525) begin
      n_fail++;
      $display("FAIL hold_until_edge got %0d exp 2525", if0.A_0_re);
    end
    step();
    exp = pk(1000, 908, 2730, -400, 908, -2730);
    got = snap0();
    for (int i = 0; i < 6; i++) begin
      n_run++;
      if (got[(5-i)*16 +: 16] !== exp[(5-i)*16 +: 16]) begin
        n_fail++;
        $display("FAIL cycB_w_%s got %0d exp %0d", nm[i],
                 $signed(got[(5-i)*16 +: 16]), $signed(exp[(5-i)*16 +: 16]));
      end
    end
    got = snap1();
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL cycB_s got %h exp %h", got, exp);
    end
  endtask

  task automatic test_chain();
    logic [95:0] got, exp;
    x0 = 16'sd501; x4 = 16'sd2324; x2 = 16'sd230; x6 = -16'sd530;
    step();
    n_run++;
    if (ifc.A_0_re !== 16'sd0) begin
      n_fail++;
      $display("FAIL chain_latency got %0d exp 0", ifc.A_0_re);
    end
    step();
    got = snapc();
    exp = pk(2525, -1823, -760, 3125, -1823, 760);
    for (int i = 0; i < 6; i++) begin
      n_run++;
      if (got[(5-i)*16 +: 16] !== exp[(5-i)*16 +: 16]) begin
        n_fail++;
        $display("FAIL chain_%s got %0d exp %0d", nm[i],
                 $signed(got[(5-i)*16 +: 16]), $signed(exp[(5-i)*16 +: 16]));
      end
    end
  endtask

  task automatic test_overflow_high();
    logic [95:0] got, exp;
    drive(32767, 0, 1, -32768);
    step();
    got = snap0();
    exp = pk(-32768, 0, -32768, 32766, 0, -32768);
    for (int i = 0; i < 6; i++) begin
      n_run++;
      if (got[(5-i)*16 +: 16] !== exp[(5-i)*16 +: 16]) begin
        n_fail++;
        $display("FAIL ovf_wrap_%s got %0d exp %0d", nm[i],
                 $signed(got[(5-i)*16 +: 16]), $signed(exp[(5-i)*16 +: 16]));
      end
    end
    got = snap1();
    exp = pk(32767, 0, 32767, 32766, 0, -32768);
    for (int i = 0; i < 6; i++) begin
      n_run++;
      if (got[(5-i)*16 +: 16] !== exp[(5-i)*16 +: 16]) begin
        n_fail++;
        $display("FAIL ovf_sat_%s got %0d exp %0d", nm[i],
                 $signed(got[(5-i)*16 +: 16]), $signed(exp[(5-i)*16 +: 16]));
      end
    end
  endtask

  task automatic test_overflow_low();
    logic [95:0] got, exp;
    drive(-32768, -32768, 1, 32767);
    step();
    got = snap0();
    exp = pk(-32767, -32768, -32767, 32767, -32768, 32767);
    for (int i = 0; i < 6; i++) begin
      n_run++;
      if (got[(5-i)*16 +: 16] !== exp[(5-i)*16 +: 16]) begin
        n_fail++;
        $display("FAIL unf_wrap_%s got %0d exp %0d", nm[i],
                 $signed(got[(5-i)*16 +: 16]), $signed(exp[(5-i)*16 +: 16]));
      end
    end
    got = snap1();
    exp = pk(-32767, -32768, -32767, -32768, -32768, 32767);
    for (int i = 0; i < 6; i++) begin
      n_run++;
      if (got[(5-i)*16 +: 16] !== exp[(5-i)*16 +: 16]) begin
        n_fail++;
        $display("FAIL unf_sat_%s got %0d exp %0d", nm[i],
                 $signed(got[(5-i)*16 +: 16]), $signed(exp[(5-i)*16 +: 16]));
      end
    end
    // large positive sum: wraps to -2, clamps to the top
    drive(32767, 5, 32767, 0);
    step();
    n_run++;
    if (if0.A_0_re !== -16'sd2) begin
      n_fail++;
      $display("FAIL sum_wrap got %0d exp -2", if0.A_0_re);
    end
    n_run++;
    if (if1.A_0_re !== 16'sd32767) begin
      n_fail++;
      $display("FAIL sum_sat got %0d exp 32767", if1.A_0_re);
    end
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    reset  = 1'b1;
    x0 = '0; x4 = '0; x2 = '0; x6 = '0;
    drive(0, 0, 0, 0);
    #3;
    test_reset();
    test_back_to_back();
    test_chain();
    test_overflow_high();
    test_overflow_low();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
